digit_scan: RTL and testbench

DIGIT_SCAN -- requirements
Module: digit_scan

---
 rtl/digit_scan_pkg.sv | 19 +
 rtl/digit_scan_lz_mask.sv | 20 ++
 rtl/digit_scan.sv | 112 +++++++++++
 tb/tb_digit_scan.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_scan_pkg.sv
// Shared constants, scan state encoding and nibble select helper for the
// multiplexed 7-segment digit scanner.
package digit_scan_pkg;

  localparam int NUM_DIGITS      = 4;
  localparam int DEF_REFRESH_DIV = 50000;
  localparam int DEF_BLANK_CYC   = 500;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic logic [3:0] nibble_of(input logic [4*NUM_DIGITS-1:0] frame,
                                           input logic [1:0] idx);
    return frame[4*idx +: 4];
  endfunction

endpackage

// File: rtl/digit_scan_lz_mask.sv
// Leading-zero visibility mask: digit i is visible unless blanking is on and
// every nibble from i up to the most significant digit is zero.
module lz_mask
  import digit_scan_pkg::*;
(
  input  logic [4*NUM_DIGITS-1:0] frame,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   visible
);

  // The rightmost digit always shows, so an all-zero value still reads "0".
  assign visible[0] = 1'b1;

  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_vis
      assign visible[gi] = !lz_blank || (|frame[4*NUM_DIGITS-1:4*gi]);
    end
  endgenerate

endmodule

// File: rtl/digit_scan.sv
// Four-digit display scanner: steps dp through the digits every REFRESH_DIV
// clocks, latches value once per frame and drives fully registered outputs.
module digit_scan
  import digit_scan_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int BLANK_CYC   = DEF_BLANK_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dig_en,
  input  logic        lz_blank,
  output logic [1:0]  dp,
  output logic [3:0]  nibble,
  output logic        digit_on,
  output logic        frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    dp_reg, dp_next;
  logic [15:0]   frame_reg, frame_next;
  logic [3:0]    nibble_reg, nibble_next;
  logic          digit_on_reg, digit_on_next;
  logic          frame_start_reg, frame_start_next;
  logic [3:0]    visible_next;

  // Mask is taken from the frame value that will be live after this edge,
  // keeping it aligned with the registered dp/nibble.
  lz_mask u_lz_mask (
    .frame    (frame_next),
    .lz_blank (lz_blank),
    .visible  (visible_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      dp_reg          <= '0;
      frame_reg       <= '0;
      nibble_reg      <= '0;
      digit_on_reg    <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      dp_reg          <= dp_next;
      frame_reg       <= frame_next;
      nibble_reg      <= nibble_next;
      digit_on_reg    <= digit_on_next;
      frame_start_reg <= frame_start_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    dp_next          = dp_reg;
    frame_next       = frame_reg;
    frame_start_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (en) begin
          state_next       = SCAN;
          cnt_next         = '0;
          dp_next          = '0;
          frame_next       = value;
          frame_start_next = 1'b1;
        end
      end
      SCAN: begin
        if (!en) begin
          state_next = IDLE;
          cnt_next   = '0;
          dp_next    = '0;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          dp_next  = dp_reg + 2'd1;
          // Relatch only on the 3->0 wrap so a frame never tears.
          if (dp_reg == 2'd3) begin
            frame_next       = value;
            frame_start_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        dp_next    = '0;
      end
    endcase

    nibble_next   = nibble_of(frame_next, dp_next);
    digit_on_next = (state_next == SCAN) && (int'(cnt_next) >= BLANK_CYC) &&
                    dig_en[dp_next] && visible_next[dp_next];
  end

  assign dp          = dp_reg;
  assign nibble      = nibble_reg;
  assign digit_on    = digit_on_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_digit_scan.sv
// Directed bench for digit_scan with REFRESH_DIV=8, BLANK_CYC=2.
module tb_digit_scan;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dig_en;
  logic        lz_blank;
  logic [1:0]  dp;
  logic [3:0]  nibble;
  logic        digit_on;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;

  digit_scan #(
    .REFRESH_DIV (8),
    .BLANK_CYC   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .value       (value),
    .dig_en      (dig_en),
    .lz_blank    (lz_blank),
    .dp          (dp),
    .nibble      (nibble),
    .digit_on    (digit_on),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of frame cycle k=0 (first SCAN cycle).
  task automatic start_scan();
    en = 1'b0;
    step();
    en = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; value = 16'h1234; dig_en = 4'hF; lz_blank = 1'b0;
    #1;
    n_cmp++;
    if ({dp, nibble, digit_on, frame_start} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got dp=%0d nib=%h on=%b fs=%b, want all 0", dp, nibble, digit_on, frame_start);
    end
    step(); step();
    rst_n = 1'b1;
    step(); step();
    n_cmp++;
    if ({dp, nibble, digit_on, frame_start} !== 8'h00) begin
      n_err++;
      $display("FAIL idle_after_reset: got dp=%0d nib=%h on=%b fs=%b, want all 0", dp, nibble, digit_on, frame_start);
    end
    $display("test_reset done");
  endtask

  task automatic test_scan();
    logic [3:0] exp_nib [4];
    logic exp_on;
    exp_nib = '{4'h4, 4'h3, 4'h2, 4'h1};
    value = 16'h1234; dig_en = 4'hF; lz_blank = 1'b0;
    start_scan();
    for (int k = 0; k <= 32; k++) begin
      exp_on = ((k % 8) >= 2);
      n_cmp++;
      if (dp !== 2'((k / 8) % 4) || nibble !== exp_nib[(k / 8) % 4] ||
          digit_on !== exp_on || frame_start !== ((k % 32) == 0)) begin
        n_err++;
        $display("FAIL scan k=%0d: got dp=%0d nib=%h on=%b fs=%b, want dp=%0d nib=%h on=%b fs=%b",
                 k, dp, nibble, digit_on, frame_start, (k / 8) % 4, exp_nib[(k / 8) % 4],
                 exp_on, ((k % 32) == 0));
      end
      step();
    end
    $display("test_scan done");
  endtask

  task automatic test_lz_blank();
    logic [3:0] exp_nib [4];
    logic       exp_lit [4];
    exp_nib = '{4'h0, 4'h5, 4'h0, 4'h0};
    exp_lit = '{1'b1, 1'b1, 1'b0, 1'b0};
    value = 16'h0050; dig_en = 4'hF; lz_blank = 1'b1;
    start_scan();
    for (int k = 0; k < 32; k++) begin
      n_cmp++;
      if (nibble !== exp_nib[k / 8] || digit_on !== (exp_lit[k / 8] && (k % 8) >= 2)) begin
        n_err++;
        $display("FAIL lz_blank k=%0d: got nib=%h on=%b, want nib=%h on=%b",
                 k, nibble, digit_on, exp_nib[k / 8], exp_lit[k / 8] && (k % 8) >= 2);
      end
      step();
    end
    $display("test_lz_blank done");
  endtask

  task automatic test_all_zero();
    value = 16'h0000; dig_en = 4'hF; lz_blank = 1'b1;
    start_scan();
    for (int k = 0; k < 32; k++) begin
      n_cmp++;
      if (nibble !== 4'h0 || digit_on !== ((k / 8) == 0 && (k % 8) >= 2)) begin
        n_err++;
        $display("FAIL all_zero k=%0d: got nib=%h on=%b, want nib=0 on=%b",
                 k, nibble, digit_on, ((k / 8) == 0 && (k % 8) >= 2));
      end
      step();
    end
    $display("test_all_zero done");
  endtask

  task automatic test_tear_free();
    logic [3:0] nib_a [4];
    logic [3:0] nib_b [4];
    logic [3:0] want;
    nib_a = '{4'h4, 4'h3, 4'h2, 4'h1};
    nib_b = '{4'hD, 4'hC, 4'hB, 4'hA};
    value = 16'h1234; dig_en = 4'hF; lz_blank = 1'b0;
    start_scan();
    for (int k = 0; k < 64; k++) begin
      want = (k < 32) ? nib_a[(k / 8) % 4] : nib_b[(k / 8) % 4];
      n_cmp++;
      if (nibble !== want || frame_start !== ((k % 32) == 0)) begin
        n_err++;
        $display("FAIL tear_free k=%0d: got nib=%h fs=%b, want nib=%h fs=%b",
                 k, nibble, frame_start, want, ((k % 32) == 0));
      end
      if (k == 10) value = 16'hABCD;
      step();
    end
    $display("test_tear_free done");
  endtask

  task automatic test_mask_enable();
    value = 16'h1234; dig_en = 4'b1011; lz_blank = 1'b0;
    start_scan();
    for (int k = 0; k < 32; k++) begin
      n_cmp++;
      if (digit_on !== ((k / 8) != 2 && (k % 8) >= 2)) begin
        n_err++;
        $display("FAIL dig_en_mask k=%0d: got on=%b, want %b", k, digit_on, ((k / 8) != 2 && (k % 8) >= 2));
      end
      step();
    end
    // now at dp=0 cnt=0 of the second frame; move to dp=1 cnt=3
    for (int k = 0; k < 11; k++) step();
    n_cmp++;
    if (dp !== 2'd1 || digit_on !== 1'b1) begin
      n_err++;
      $display("FAIL mid_slot_pos: got dp=%0d on=%b, want dp=1 on=1", dp, digit_on);
    end
    en = 1'b0;
    step();
    n_cmp++;
    if (dp !== 2'd0 || digit_on !== 1'b0 || frame_start !== 1'b0) begin
      n_err++;
      $display("FAIL en_drop: got dp=%0d on=%b fs=%b, want dp=0 on=0 fs=0", dp, digit_on, frame_start);
    end
    step();
    en = 1'b1;
    step();
    n_cmp++;
    if (frame_start !== 1'b1 || dp !== 2'd0 || digit_on !== 1'b0 || nibble !== 4'h4) begin
      n_err++;
      $display("FAIL en_reraise: got fs=%b dp=%0d on=%b nib=%h, want fs=1 dp=0 on=0 nib=4",
               frame_start, dp, digit_on, nibble);
    end
    step(); step();
    n_cmp++;
    if (frame_start !== 1'b0 || dp !== 2'd0 || digit_on !== 1'b1) begin
      n_err++;
      $display("FAIL en_restart_lit: got fs=%b dp=%0d on=%b, want fs=0 dp=0 on=1", frame_start, dp, digit_on);
    end
    $display("test_mask_enable done");
  endtask

  task automatic test_reset_mid_scan();
    value = 16'h1234; dig_en = 4'hF; lz_blank = 1'b0;
    start_scan();
    for (int k = 0; k < 21; k++) step();
    n_cmp++;
    if (dp !== 2'd2 || nibble !== 4'h2 || digit_on !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_pos: got dp=%0d nib=%h on=%b, want dp=2 nib=2 on=1", dp, nibble, digit_on);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dp, nibble, digit_on, frame_start} !== 8'h00) begin
      n_err++;
      $display("FAIL async_reset: got dp=%0d nib=%h on=%b fs=%b, want all 0", dp, nibble, digit_on, frame_start);
    end
    step(); step();
    n_cmp++;
    if ({dp, nibble, digit_on, frame_start} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_hold: got dp=%0d nib=%h on=%b fs=%b, want all 0", dp, nibble, digit_on, frame_start);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (frame_start !== 1'b1 || dp !== 2'd0 || nibble !== 4'h4 || digit_on !== 1'b0) begin
      n_err++;
      $display("FAIL resume_after_reset: got fs=%b dp=%0d nib=%h on=%b, want fs=1 dp=0 nib=4 on=0",
               frame_start, dp, nibble, digit_on);
    end
    $display("test_reset_mid_scan done");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz_blank();
    test_all_zero();
    test_tear_free();
    test_mask_enable();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
